// File: rtl/seq_div_8by4_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_8by4_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_restore_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] r_in,
  input  logic          dbit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_out,
  output logic          qbit
);
  logic [VW:0]   sh;
  logic [VW-1:0] diff;

  assign sh   = {r_in, dbit};
  assign qbit = (sh >= {1'b0, divisor});
  // When the subtract is taken the result is < divisor, so the low VW bits
  // of the modular difference are exact.
  assign diff  = sh[VW-1:0] - divisor;
  assign r_out = qbit ? diff : sh[VW-1:0];
endmodule

// File: rtl/seq_div_8by4.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional SEQ_DIV_EARLY_EXIT_EN: finish immediately when dividend < divisor.
module seq_div_8by4
  import seq_div_8by4_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state, state_nx;
  logic [DW-1:0] dvd, q_sh;
  logic [VW-1:0] dvs, r, r_step;
  logic [CW-1:0] cnt;
  logic          qbit, zero_div, early;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero_div  = (divisor == '0);

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early = !zero_div && (dividend < {{(DW-VW){1'b0}}, divisor});
`else
  assign early = 1'b0;
`endif

  div_restore_step #(.VW(VW)) u_step (
    .r_in   (r),
    .dbit   (dvd[DW-1]),
    .divisor(dvs),
    .r_out  (r_step),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (zero_div || early) ? DONE : RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
      q_sh      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd  <= dividend;
          dvs  <= divisor;
          r    <= '0;
          q_sh <= '0;
          cnt  <= CW'(DW - 1);
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dividend[VW-1:0];
            div_zero  <= 1'b1;
          end else if (early) begin
            quotient  <= '0;
            remainder <= dividend[VW-1:0];
            div_zero  <= 1'b0;
          end
        end
        RUN: begin
          r    <= r_step;
          dvd  <= {dvd[DW-2:0], 1'b0};
          q_sh <= {q_sh[DW-2:0], qbit};
          cnt  <= cnt - 1'b1;
          // Result registers only move on the last step so they hold between ops.
          if (cnt == '0) begin
            quotient  <= {q_sh[DW-2:0], qbit};
            remainder <= r_step;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_8by4.sv
// Self-checking bench for seq_div_8by4: directed table, backpressure, mid-op reset, full sweep, random ops.
module tb_seq_div_8by4;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int EL = 0;
`else
  localparam int EL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [7:0] dividend, quotient;
  logic [3:0] divisor, remainder;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_8by4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  typedef struct {
    int a, b, q, r, dz, lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division; lat = edges after the accept edge until out_valid.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int dz, output int lat);
    if (b == 0) begin
      q = 255; r = a % 16; dz = 1; lat = 0;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = 8;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      if (a < b) lat = 0;
`endif
    end
  endfunction

  task automatic run_op(input int a, input int b, input int hold,
                        output int q, output int r, output int dz, output int lat);
    @(negedge clk);
    chk("idle_before_op", int'(in_ready), 1);
    dividend = 8'(a); divisor = 4'(b); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    q = int'(quotient); r = int'(remainder); dz = int'(div_zero);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", int'(out_valid), 0);
    chk("in_ready_after_take", int'(in_ready), 1);
    chk("quotient_holds", int'(quotient), q);
  endtask

  task automatic check_op(input string nm, input int a, input int b, input int hold,
                          input int eq, input int er, input int edz, input int elat);
    int q, r, dz, lat;
    run_op(a, b, hold, q, r, dz, lat);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_dz"}, dz, edz);
    chk({nm, "_lat"}, lat, elat);
  endtask

  initial begin
    vec_t tbl[$];
    int eq, er, edz, elat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_div_zero", int'(div_zero), 0);

    tbl.push_back('{200, 7, 28, 4, 0, 8});
    tbl.push_back('{255, 1, 255, 0, 0, 8});
    tbl.push_back('{0, 5, 0, 0, 0, EL});
    tbl.push_back('{255, 15, 17, 0, 0, 8});
    tbl.push_back('{13, 0, 255, 13, 1, 0});
    tbl.push_back('{3, 9, 0, 3, 0, EL});
    tbl.push_back('{15, 15, 1, 0, 0, 8});
    tbl.push_back('{7, 8, 0, 7, 0, EL});
    tbl.push_back('{129, 2, 64, 1, 0, 8});
    for (int i = 0; i < tbl.size(); i++)
      check_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, i % 3,
               tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);

    // Backpressure: hold result 5 cycles while in_valid pulses with other operands.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; dividend = 8'd9; divisor = 4'd2;
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_quotient", int'(quotient), 28);
      chk("bp_remainder", int'(remainder), 4);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp_idle_after", int'(in_ready), 1);
      chk("bp_no_ghost_op", int'(out_valid), 0);
    end

    // Reset in the middle of 100/3, then a clean 100/3.
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_div_zero", int'(div_zero), 0);
    check_op("after_rst", 100, 3, 0, 33, 1, 0, 8);

    // Exhaustive operand sweep against the arithmetic model.
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) begin
        model(a, b, eq, er, edz, elat);
        check_op("sweep", a, b, 0, eq, er, edz, elat);
      end

    // Random operands with random downstream stalls.
    for (int i = 0; i < 100; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      model(a, b, eq, er, edz, elat);
      check_op("rand", a, b, int'($urandom_range(0, 3)), eq, er, edz, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
